// File: rtl/fsm_ser_tx.sv
// Parallel-to-serial transmitter: one WIDTH-bit word per handshake, shifted out one bit per clock.
// Optional even-parity bit after the data bits when PARITY_EN is defined.
module fsm_ser_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned GAP       = 1,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GAP_W = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd3
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
`ifdef PARITY_EN
    logic               par_q, par_d;
`endif
    logic               ready_d, out_d, valid_d, busy_d, done_d;
    logic               end_word;

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
`ifdef PARITY_EN
            par_q     <= 1'b0;
`endif
            din_ready <= 1'b0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
`ifdef PARITY_EN
            par_q     <= par_d;
`endif
            din_ready <= ready_d;
            ser_out   <= out_d;
            ser_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
`ifdef PARITY_EN
        par_d     = par_q;
`endif
        ready_d   = 1'b0;
        out_d     = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        end_word  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (din_valid && din_ready) begin
                    // First bit leaves on this edge; the register keeps the rest.
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    shreg_d   = MSB_FIRST ? (din << 1) : (din >> 1);
                    out_d     = MSB_FIRST ? din[WIDTH-1] : din[0];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
`ifdef PARITY_EN
                    par_d     = ^din;
`endif
                end
            end

            ST_SHIFT: begin
                busy_d = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
`ifdef PARITY_EN
                    state_d = ST_PAR;
                    out_d   = par_q;
                    valid_d = 1'b1;
`else
                    end_word = 1'b1;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    out_d     = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                    shreg_d   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    valid_d   = 1'b1;
                end
            end

`ifdef PARITY_EN
            ST_PAR: begin
                end_word = 1'b1;
            end
`endif

            ST_GAP: begin
                busy_d = 1'b1;
                if (gap_cnt_q == LAST_GAP) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Last serial bit has left: pulse done and either rest in the gap or reopen at once.
        if (end_word) begin
            done_d = 1'b1;
            if (GAP == 0) begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end else begin
                state_d   = ST_GAP;
                gap_cnt_d = '0;
                busy_d    = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fsm_ser_tx.sv
// Bench for fsm_ser_tx: three configurations share one stimulus; each is checked every
// cycle against a cycle-offset model of the transmitted frame.
module tb_fsm_ser_tx;

    localparam int NI = 3;
    localparam int CW [NI] = '{8, 8, 5};
    localparam int CG [NI] = '{1, 0, 2};
    localparam int CM [NI] = '{1, 1, 0};
`ifdef PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic rdy;
        logic so;
        logic sv;
        logic bsy;
        logic dn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic [NI-1:0] rdy, so, sv, bsy, dn;

    int          k    [NI];
    bit          up   [NI];
    logic [31:0] word [NI];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    fsm_ser_tx #(.WIDTH(8), .GAP(1), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy[0]), .ser_out(so[0]), .ser_valid(sv[0]), .busy(bsy[0]), .done(dn[0]));

    fsm_ser_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy[1]), .ser_out(so[1]), .ser_valid(sv[1]), .busy(bsy[1]), .done(dn[1]));

    fsm_ser_tx #(.WIDTH(5), .GAP(2), .MSB_FIRST(1'b0)) u_c (
        .clk(clk), .rst(rst), .din(din[4:0]), .din_valid(din_valid),
        .din_ready(rdy[2]), .ser_out(so[2]), .ser_valid(sv[2]), .busy(bsy[2]), .done(dn[2]));

    // Expected outputs k cycles after acceptance: data bits, optional parity, done, gap, ready.
    function automatic exp_t model_out(int i);
        exp_t e;
        int   w;
        int   d;
        int   idx;
        e = '0;
        w = CW[i];
        d = w + 1 + PAR;
        if (!up[i]) return e;
        if (k[i] < 1) begin
            e.rdy = 1'b1;
            return e;
        end
        if (k[i] <= w) begin
            idx   = (CM[i] != 0) ? (w - k[i]) : (k[i] - 1);
            e.so  = word[i][idx];
            e.sv  = 1'b1;
            e.bsy = 1'b1;
        end else if (PAR == 1 && k[i] == w + 1) begin
            e.so  = ^word[i];
            e.sv  = 1'b1;
            e.bsy = 1'b1;
        end else if (k[i] < d + CG[i]) begin
            e.bsy = 1'b1;
            e.dn  = (k[i] == d);
        end else begin
            e.rdy = 1'b1;
            e.dn  = (k[i] == d);
        end
        return e;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            e = model_out(i);
            if (e.rdy && din_valid) begin
                k[i]    = 1;
                word[i] = {24'h0, din} & ((32'd1 << CW[i]) - 32'd1);
            end else if (k[i] > 0) begin
                k[i] = k[i] + 1;
            end
            up[i] = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            k[i]    = 0;
            up[i]   = 1'b0;
            word[i] = '0;
        end
    endtask

    task automatic chk(string tag, int i, logic obs, logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d] at %0t: got %b want %b", tag, i, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            e = model_out(i);
            chk("din_ready", i, rdy[i], e.rdy);
            chk("ser_out",   i, so[i],  e.so);
            chk("ser_valid", i, sv[i],  e.sv);
            chk("busy",      i, bsy[i], e.bsy);
            chk("done",      i, dn[i],  e.dn);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        model_reset();
        #1 check_all();
        step();
        step();
        rst = 1'b1;
        check_all();
        step();

        // Single word 8'hA5, one-cycle valid
        din = 8'hA5;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        repeat (14) step();

        // Valid held: 8'hCC then 8'h33 presented while the first word is in flight
        din = 8'hCC;
        din_valid = 1'b1;
        step();
        din = 8'h33;
        repeat (22) step();
        din_valid = 1'b0;
        repeat (14) step();

        // Parity-relevant words
        din = 8'h07;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        repeat (14) step();

        // Random words and valid, din changing every cycle
        repeat (120) begin
            din = 8'($urandom);
            din_valid = 1'($urandom_range(0, 1));
            step();
        end
        din_valid = 1'b0;
        repeat (14) step();

        // Reset asserted mid-word, between clock edges
        din = 8'hFF;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        repeat (3) step();
        @(posedge clk);
        model_edge();
        #2 rst = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        rst = 1'b1;
        check_all();
        step();
        din = 8'h01;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        repeat (14) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fsm_ser_tx.md
Name: fsm_ser_tx

Overview:
Parallel-to-serial transmitter FSM that produces the serial bitstream consumed by the serial pair-detector blocks.
- Accepts one WIDTH-bit word per valid/ready handshake.
- Shifts the word out one bit per clock on ser_out, qualified by ser_valid.
- Inserts a configurable idle gap between words.
- Pulses done after each completed word.

Parameters:
WIDTH, 8, data word width in bits (2..32).
GAP, 1, idle cycles between words (0..15); ser_valid=0 and ser_out=0 during the gap.
MSB_FIRST, 1, 1: transmit din[WIDTH-1] first; 0: transmit din[0] first.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-low.
din  input  WIDTH  parallel word to transmit.
din_valid  input  1  din holds a word to send.
din_ready  output  1  block can accept a word this cycle.
ser_out  output  1  serial data bit.
ser_valid  output  1  ser_out carries a data or parity bit this cycle.
busy  output  1  high from acceptance until the end of the gap.
done  output  1  one-cycle pulse on the cycle after the last transmitted bit.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; shift register, bit counter and gap counter cleared.
  - ser_out=0, ser_valid=0, busy=0, done=0, din_ready=0.
  - din_ready rises on the first clock edge after rst deasserts.
- All outputs are registered. No combinational path exists from din or din_valid to any output.
- Accept rule: a word is accepted on a rising edge where din_valid=1 and din_ready=1. din_ready is 1 only in IDLE.
- States: IDLE, SHIFT, PAR (only when PARITY_EN is defined), GAP.
- IDLE:
  - On accept, latch din into the shift register, clear the bit counter and go to SHIFT.
  - On the same edge: din_ready<=0, busy<=1, ser_valid<=1, ser_out<=first bit.
- SHIFT:
  - One bit per cycle; ser_valid=1 throughout.
  - The first bit appears the cycle after acceptance (1-cycle latency). The WIDTH bits occupy WIDTH consecutive cycles.
  - After the last bit: go to PAR if PARITY_EN is defined; otherwise go to GAP, or to IDLE when GAP=0.
- On leaving the last serial bit:
  - ser_valid<=0, ser_out<=0, done<=1 for exactly one cycle.
- GAP:
  - The counter runs GAP cycles, with busy=1 and ser_valid=0.
  - On expiry go to IDLE: busy<=0, din_ready<=1.
- Throughput:
  - GAP=0, no parity: one word per WIDTH+1 cycles.
  - General case: WIDTH+GAP+1 cycles, plus 1 cycle with parity.
- din_valid is ignored outside IDLE, and din changes after acceptance have no effect.
- done and din_ready:
  - With GAP=0, done and din_ready are both 1 in the same cycle.
  - A word accepted in that cycle starts transmitting on the next cycle, with no idle bit.
- Reset asserted mid-word aborts the transmission immediately: outputs go to reset values, with no done pulse and no partial parity.
- Illegal state encodings recover to IDLE on the next edge.

Optional Feature:
PARITY_EN
- Defined:
  - The PAR state follows SHIFT and emits one extra bit with ser_valid=1.
  - The bit is even parity: XOR of all WIDTH data bits.
  - done pulses after the parity bit.
- Undefined: the PAR state and parity logic are absent; the sequence is data bits only, then GAP.

Test Plan:
- Reset, then din=8'hA5, din_valid=1 for one cycle (MSB_FIRST=1, GAP=1) -> din_ready high one cycle after reset release; ser_out=1,0,1,0,0,1,0,1 on cycles 1..8 after accept with ser_valid=1; done=1 on cycle 9; din_ready=1 on cycle 10.
- MSB_FIRST=0, din=8'h01 -> ser_out=1 then seven 0s; ser_valid high exactly 8 cycles.
- GAP=0, din_valid held high with words 8'hCC then 8'h33 -> bitstream 1,1,0,0,1,1,0,0, one idle cycle (ser_valid=0), then 0,0,1,1,0,0,1,1.
- PARITY_EN defined: din=8'h07 -> 8 data bits then parity bit 1 with ser_valid=1; din=8'hA5 -> parity bit 0; done follows the parity bit.
- Assert rst low after bit 4 of 8'hFF -> ser_out, ser_valid and busy go to 0 without a clock edge; no done pulse; after release the next word transmits normally from bit 0.
- din_valid=1 while busy, with din changing each cycle -> no effect on the current word; the new word is accepted only when din_ready=1.
